// File: rtl/fp32_operand_serializer.sv
// fp32_operand_serializer
//
// Feeds the bit-serial FP32 adder (add_float). Operand pairs arrive as
// parallel words over a valid/ready handshake. Each pair is streamed as one
// frame: A MSB-first, then B MSB-first. The adder's active-low start strobe
// `go` is held low from START until the adder reports `done`.
//
// A one-entry pending buffer lets the next pair be accepted while the
// current frame is still streaming.
//
// Handshake: a pair on op_a/op_b transfers on a rising edge where in_valid
// and in_ready are both 1. in_ready depends only on the pending-buffer flag,
// never on in_valid. The producer must hold in_valid and the operands
// stable until the pair transfers.
//
// Optional build macro: FP32SER_TIMEOUT_EN
//   Adds a watchdog on the WAIT state. After TIMEOUT_CYCLES waiting cycles
//   without adder_done, it emits a one-cycle `timeout` pulse and returns to
//   IDLE. Without the macro, `timeout` is tied to 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   in_valid    operand pair valid
//   in_ready    pending buffer empty (combinational from pend_valid only)
//   op_a, op_b  operands, WIDTH bits each
//   go          adder start strobe, active-low, registered
//   inpab       serial operand bit, registered
//   adder_done  completion from add_float (only looked at in WAIT)
//   busy        registered, state != IDLE
//   timeout     registered watchdog pulse
//   state_dbg   current FSM state (0 IDLE, 1 START, 2 SEND, 3 WAIT)

module fp32_operand_serializer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             go,
    output logic             inpab,
    input  logic             adder_done,
    output logic             busy,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    localparam int FRAME = 2 * WIDTH;
    localparam int CW    = $clog2(FRAME) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME-1:0]   pend_q;
    logic               pend_valid_q;
    logic [FRAME-1:0]   shreg_q;
    logic [CW-1:0]      cnt_q;
    logic               go_q, inpab_q, busy_q, timeout_q;
    logic               go_d, inpab_d, busy_d, timeout_d;
    logic               last_bit;
    logic               expire;
    logic               accept;

    assign in_ready  = ~pend_valid_q;
    assign accept    = in_valid & ~pend_valid_q;
    assign last_bit  = (cnt_q == CW'(FRAME - 1));
    assign go        = go_q;
    assign inpab     = inpab_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

`ifdef FP32SER_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0] wait_cnt_q;

    // The counter holds the number of WAIT edges already seen. The edge
    // that would make it TIMEOUT_CYCLES is the expiry edge. A done sampled
    // on that same edge takes priority.
    assign expire = (state_q == S_WAIT) && !adder_done &&
                    (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_d == S_WAIT && state_q != S_WAIT) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
        end
    end
`else
    assign expire = 1'b0;

    // The watchdog limit has no effect in this build. It is referenced here
    // only so that the parameter is not reported as unused.
    if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
    end
`endif

    // State register. The registered outputs are loaded here as well, so
    // each output changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            go_q      <= 1'b1;
            inpab_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            inpab_q   <= inpab_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pend_valid_q) state_d = S_START;
            S_START: state_d = S_SEND;
            S_SEND:  if (last_bit) state_d = S_WAIT;
            S_WAIT:  if (adder_done || expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: values that the output registers take at the next edge.
    // They are derived from the next state.
    // In SEND, the register MSB is always the next bit to present, because
    // every edge that enters or stays in SEND also shifts the register left.
    always_comb begin
        go_d      = (state_d == S_IDLE);
        busy_d    = (state_d != S_IDLE);
        inpab_d   = (state_d == S_SEND) ? shreg_q[FRAME-1] : 1'b0;
        timeout_d = expire;
    end

    // Datapath: pending buffer, shift register and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
        end else begin
            // Accept and release never coincide: a release requires
            // pend_valid=1, and in that case in_ready=0.
            if (accept) begin
                pend_q       <= {op_a, op_b};
                pend_valid_q <= 1'b1;
            end else if (state_q == S_IDLE && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end

            if (state_q == S_IDLE && pend_valid_q) begin
                shreg_q <= pend_q;
            end else if (state_d == S_SEND) begin
                shreg_q <= {shreg_q[FRAME-2:0], 1'b0};
            end

            if (state_q == S_START) begin
                cnt_q <= '0;
            end else if (state_q == S_SEND && state_d == S_SEND) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule
